// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues rd/done reads to instruction
// memory and presents instr/pc/pc_plus_two to decode, with a one-entry skid buffer.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OPC = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] next_pc,
    input  logic        pc_load,
    input  logic        stall,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus_two,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [2:0] {IDLE, WAIT, DROP, FULL, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] fetch_pc;
    logic [15:0] skid_instr, skid_pc;
    logic        slot_free, flush, complete;
    logic        capture, to_skid, skid_out;

    function automatic logic [15:0] pc_inc(input logic [15:0] a);
        return a + 16'd2;
    endfunction

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == HALT_OPC;
    endfunction

    assign slot_free = !(stall && instr_valid);
    assign flush     = pc_load && (state != HALTED);
    assign imem_addr = fetch_pc;
    assign halted    = (state == HALTED);

    always_comb begin
        state_nxt = state;
        imem_rd   = 1'b0;
        complete  = 1'b0;
        capture   = 1'b0;
        to_skid   = 1'b0;
        skid_out  = 1'b0;
        unique case (state)
            IDLE: begin
                // A same-cycle done is treated exactly like WAIT followed by done.
                if (!pc_load && slot_free && !rst) begin
                    imem_rd = 1'b1;
                    if (imem_done) complete = 1'b1;
                    else           state_nxt = WAIT;
                end
            end
            WAIT: begin
                imem_rd = 1'b1;
                if (pc_load)        state_nxt = imem_done ? IDLE : DROP;
                else if (imem_done) complete = 1'b1;
            end
            DROP: begin
                imem_rd = 1'b1;
                if (imem_done) state_nxt = IDLE;
            end
            FULL: begin
                if (pc_load) begin
                    state_nxt = IDLE;
                end else if (!stall) begin
                    skid_out  = 1'b1;
                    state_nxt = is_halt(skid_instr) ? HALTED : IDLE;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            if (slot_free) begin
                capture   = 1'b1;
                state_nxt = is_halt(imem_data) ? HALTED : IDLE;
            end else begin
                to_skid   = 1'b1;
                state_nxt = FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            instr       <= 16'h0800;
            pc          <= 16'h0000;
            pc_plus_two <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush)         fetch_pc <= next_pc;
            else if (complete) fetch_pc <= pc_inc(fetch_pc);
            // Output slot is one-shot: a delivered instruction is dropped once taken.
            if (flush)                    instr_valid <= 1'b0;
            else if (capture || skid_out) instr_valid <= 1'b1;
            else if (!stall)              instr_valid <= 1'b0;
            if (capture) begin
                instr       <= imem_data;
                pc          <= fetch_pc;
                pc_plus_two <= pc_inc(fetch_pc);
            end else if (skid_out) begin
                instr       <= skid_instr;
                pc          <= skid_pc;
                pc_plus_two <= pc_inc(skid_pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (to_skid) begin
            skid_instr <= imem_data;
            skid_pc    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against
// a stream-level model of which PCs must be delivered and what memory holds there.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, pc_load, stall;
    logic [15:0] next_pc, imem_addr, imem_data, instr, pc, pc_plus_two;
    logic        imem_rd, imem_done, instr_valid, halted;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: per-access latency, optional single-word override
    bit          rand_lat  = 1'b0;
    int          fixed_lat = 0;
    int          lat       = 0;
    int          wcnt      = 0;
    bit          ovr_en    = 1'b0;
    logic [15:0] ovr_addr  = 16'h0000;
    logic [15:0] ovr_data  = 16'h0000;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .HALT_OPC(5'b00000)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .pc_load(pc_load), .stall(stall),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .imem_done(imem_done), .instr(instr), .pc(pc), .pc_plus_two(pc_plus_two),
        .instr_valid(instr_valid), .halted(halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return ((a * 16'h9E37) ^ 16'h5A5A) | 16'h8000;
    endfunction

    assign imem_done = imem_rd && (wcnt >= (rand_lat ? lat : fixed_lat));
    assign imem_data = !imem_done ? 16'hDEAD :
                       (ovr_en && imem_addr == ovr_addr) ? ovr_data : mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_rd || imem_done) begin
            wcnt <= 0;
            if (imem_done) lat <= $urandom_range(0, 3);
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rd_cycles;
        bit          got;
        logic [15:0] exp_pc, prev_next, prev_addr, prev_instr, prev_pc;
        logic        prev_valid, prev_stall, prev_pc_load, prev_rd, prev_done;
        int          deliveries;

        rst = 1'b1; pc_load = 1'b0; stall = 1'b0; next_pc = 16'h0000;
        ovr_en = 1'b1; ovr_addr = 16'h0000; ovr_data = 16'h4123; fixed_lat = 0;
        tick(); tick();
        check("rst_instr", instr, 16'h0800);
        check("rst_pc", pc, 16'h0000);
        check("rst_ppt", pc_plus_two, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_rd", imem_rd, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);

        // Zero-wait first fetch
        rst = 1'b0; #1;
        check("t1_rd", imem_rd, 1'b1);
        check("t1_addr", imem_addr, 16'h0000);
        tick();
        check("t1_instr", instr, 16'h4123);
        check("t1_pc", pc, 16'h0000);
        check("t1_ppt", pc_plus_two, 16'h0002);
        check("t1_valid", instr_valid, 1'b1);
        stall = 1'b1; #1;
        check("t1_next_addr", imem_addr, 16'h0002);
        check("t1_stall_no_rd", imem_rd, 1'b0);

        // Three wait states: rd held four cycles at a stable address
        fixed_lat = 3; stall = 1'b0; #1;
        rd_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_rd) begin
                rd_cycles++;
                check("t2_addr", imem_addr, 16'h0002);
            end
            if (imem_done) break;
            tick();
        end
        check("t2_rd_cycles", rd_cycles, 4);
        tick();
        stall = 1'b1; #1;
        check("t2_instr", instr, mem_word(16'h0002));
        check("t2_pc", pc, 16'h0002);
        check("t2_valid", instr_valid, 1'b1);

        // Stalled outputs hold, then the next fetch delivers after release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_instr", instr, mem_word(16'h0002));
            check("t3_hold_valid", instr_valid, 1'b1);
            check("t3_no_rd", imem_rd, 1'b0);
        end
        ovr_addr = 16'h0004; ovr_data = 16'hABCD; fixed_lat = 2; stall = 1'b0; #1;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (instr_valid) begin got = 1'b1; break; end
        end
        stall = 1'b1; #1;
        check("t3_delivered", got, 1'b1);
        check("t3_instr", instr, 16'hABCD);
        check("t3_pc", pc, 16'h0004);

        // Redirect while waiting: old data dropped, new stream at 0x0040
        fixed_lat = 3; stall = 1'b0; #1;
        check("t4_issue_addr", imem_addr, 16'h0006);
        tick();
        check("t4_valid_clr", instr_valid, 1'b0);
        pc_load = 1'b1; next_pc = 16'h0040; #1;
        check("t4_rd_wait", imem_rd, 1'b1);
        tick();
        pc_load = 1'b0; #1;
        check("t4_flush_valid", instr_valid, 1'b0);
        check("t4_addr", imem_addr, 16'h0040);
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (instr_valid) begin got = 1'b1; break; end
        end
        stall = 1'b1; #1;
        check("t4_delivered", got, 1'b1);
        check("t4_pc", pc, 16'h0040);
        check("t4_instr", instr, mem_word(16'h0040));

        // Wrap at the top of the address space
        pc_load = 1'b1; next_pc = 16'hFFFE; fixed_lat = 0; #1;
        tick();
        pc_load = 1'b0; stall = 1'b0; #1;
        check("t5_flush_valid", instr_valid, 1'b0);
        check("t5_rd", imem_rd, 1'b1);
        check("t5_addr", imem_addr, 16'hFFFE);
        tick();
        check("t5_pc", pc, 16'hFFFE);
        check("t5_ppt", pc_plus_two, 16'h0000);
        check("t5_instr", instr, mem_word(16'hFFFE));
        check("t5_valid", instr_valid, 1'b1);
        stall = 1'b1; #1;
        check("t5_next_addr", imem_addr, 16'h0000);

        // HALT word at 0x0000
        ovr_addr = 16'h0000; ovr_data = 16'h0000; fixed_lat = 1; stall = 1'b0; #1;
        check("t6_rd", imem_rd, 1'b1);
        tick();
        tick();
        check("t6_halted", halted, 1'b1);
        check("t6_valid", instr_valid, 1'b1);
        check("t6_instr", instr, 16'h0000);
        check("t6_rd_off", imem_rd, 1'b0);
        tick();
        check("t6_once", instr_valid, 1'b0);
        pc_load = 1'b1; next_pc = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_ign_rd", imem_rd, 1'b0);
            check("t6_ign_halted", halted, 1'b1);
            check("t6_ign_addr", imem_addr, 16'h0002);
        end
        pc_load = 1'b0; rst = 1'b1;
        tick();
        check("t6_rst_halted", halted, 1'b0);
        check("t6_rst_addr", imem_addr, RESET_PC);
        check("t6_rst_instr", instr, 16'h0800);
        rst = 1'b0;

        // Randomized run against the delivered-stream model
        ovr_en = 1'b0; rand_lat = 1'b1;
        exp_pc = RESET_PC; deliveries = 0;
        prev_valid = 1'b0; prev_stall = 1'b0; prev_pc_load = 1'b0; prev_next = 16'h0000;
        prev_rd = 1'b0; prev_done = 1'b0; prev_addr = 16'h0000;
        prev_instr = 16'h0000; prev_pc = 16'h0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall   = ($urandom_range(0, 99) < 30);
            pc_load = ($urandom_range(0, 99) < 4);
            next_pc = 16'($urandom) & 16'hFFFE;
            #1;
            if (prev_rd && !prev_done) begin
                check("r_rd_held", imem_rd, 1'b1);
                if (!prev_pc_load) check("r_addr_stable", imem_addr, prev_addr);
            end
            prev_stall = stall; prev_pc_load = pc_load; prev_next = next_pc;
            prev_rd = imem_rd; prev_done = imem_done; prev_addr = imem_addr;
            prev_valid = instr_valid; prev_instr = instr; prev_pc = pc;
            tick();
            if (prev_pc_load) begin
                check("r_flush", instr_valid, 1'b0);
                exp_pc = prev_next;
            end else if (prev_valid && prev_stall) begin
                check("r_hold_valid", instr_valid, 1'b1);
                check("r_hold_instr", instr, prev_instr);
                check("r_hold_pc", pc, prev_pc);
            end else if (instr_valid) begin
                check("r_pc", pc, exp_pc);
                check("r_instr", instr, mem_word(exp_pc));
                check("r_ppt", pc_plus_two, exp_pc + 16'd2);
                exp_pc = exp_pc + 16'd2;
                deliveries++;
            end
            check("r_not_halted", halted, 1'b0);
        end
        check("r_progress", deliveries > 150, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
